// File: rtl/traffic_scheduler.sv
// traffic_scheduler: game-state scheduler for a three-lane car game.
// Tracks the user car, two enemy cars, the score and the enemy speed, and
// runs an IDLE / RUN / CRASH state machine. Positions advance once per
// frame_tick while running; a collision freezes the scene until restart.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   frame_tick              one-cycle pulse per vertical blank
//   start                   level-sampled start/restart request
//   btn_left, btn_right     steering buttons (level)
//   car_user_x              user car x
//   car2_x/y, car3_x/y      enemy car positions
//   show_cars               draw-stage enable (RUN and CRASH)
//   crash                   collision flag
//   score                   enemies passed, saturating
//   state                   0 IDLE, 1 RUN, 2 CRASH
module traffic_scheduler #(
    parameter int unsigned CAR_WIDTH     = 22,
    parameter int unsigned CAR_HEIGHT    = 33,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned LANE0_X       = 250,
    parameter int unsigned LANE1_X       = 309,
    parameter int unsigned LANE2_X       = 368,
    parameter int unsigned ROAD_X_MIN    = 240,
    parameter int unsigned ROAD_X_MAX    = 378,
    parameter int unsigned CAR_USER_Y    = 400,
    parameter int unsigned STEP_USER     = 3,
    parameter int unsigned SPEED0        = 2,
    parameter int unsigned SPEED_MAX     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [9:0]  car_user_x,
    output logic [9:0]  car2_x,
    output logic [9:0]  car2_y,
    output logic [9:0]  car3_x,
    output logic [9:0]  car3_y,
    output logic        show_cars,
    output logic        crash,
    output logic [15:0] score,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CRASH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  ux_q, ux_d;
    logic [9:0]  c2x_q, c2x_d, c2y_q, c2y_d;
    logic [9:0]  c3x_q, c3x_d, c3y_q, c3y_d;
    logic        crash_q, crash_d;
    logic [15:0] score_q, score_d;
    logic [9:0]  speed_q, speed_d;
    logic [2:0]  wrap_q, wrap_d;
    logic [7:0]  lfsr_q, lfsr_d;

    function automatic logic [9:0] lane_x(input logic [1:0] sel);
        case (sel)
            2'd0:    return 10'(LANE0_X);
            2'd2:    return 10'(LANE2_X);
            default: return 10'(LANE1_X);
        endcase
    endfunction

    // Collision on the registered positions: horizontal overlap and vertical overlap.
    logic [9:0] dx2, dx3;
    logic       hit2, hit3, collide;

    assign dx2  = (ux_q >= c2x_q) ? ux_q - c2x_q : c2x_q - ux_q;
    assign dx3  = (ux_q >= c3x_q) ? ux_q - c3x_q : c3x_q - ux_q;
    assign hit2 = (dx2 < 10'(CAR_WIDTH))
               && ({1'b0, c2y_q} < 11'(CAR_USER_Y + CAR_HEIGHT))
               && (({1'b0, c2y_q} + 11'(CAR_HEIGHT)) > 11'(CAR_USER_Y));
    assign hit3 = (dx3 < 10'(CAR_WIDTH))
               && ({1'b0, c3y_q} < 11'(CAR_USER_Y + CAR_HEIGHT))
               && (({1'b0, c3y_q} + 11'(CAR_HEIGHT)) > 11'(CAR_USER_Y));
    assign collide = hit2 || hit3;

    // User steering, clamped to the road without underflow wrap.
    logic [10:0] ux_ext;
    logic [9:0]  ux_dec, ux_inc, ux_move;

    assign ux_ext = {1'b0, ux_q};
    assign ux_dec = (ux_ext >= 11'(ROAD_X_MIN + STEP_USER))
                  ? 10'(ux_ext - 11'(STEP_USER)) : 10'(ROAD_X_MIN);
    assign ux_inc = ((ux_ext + 11'(STEP_USER)) > 11'(ROAD_X_MAX))
                  ? 10'(ROAD_X_MAX) : 10'(ux_ext + 11'(STEP_USER));

    always_comb begin
        case ({btn_left, btn_right})
            2'b10:   ux_move = ux_dec;
            2'b01:   ux_move = ux_inc;
            default: ux_move = ux_q;
        endcase
    end

    // Enemy advance, wrap detection, score and speed bookkeeping.
    logic [10:0] y2_sum, y3_sum;
    logic        wrap2, wrap3;
    logic [1:0]  n_wrap;
    logic [3:0]  wrap_sum;
    logic [16:0] score_sum;

    assign y2_sum    = {1'b0, c2y_q} + {1'b0, speed_q};
    assign y3_sum    = {1'b0, c3y_q} + {1'b0, speed_q};
    assign wrap2     = y2_sum >= 11'(SCREEN_HEIGHT);
    assign wrap3     = y3_sum >= 11'(SCREEN_HEIGHT);
    assign n_wrap    = {1'b0, wrap2} + {1'b0, wrap3};
    assign wrap_sum  = {1'b0, wrap_q} + {2'b00, n_wrap};
    assign score_sum = {1'b0, score_q} + {15'd0, n_wrap};

    // State register (all sequential state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ux_q    <= 10'(LANE1_X);
            c2x_q   <= 10'(LANE0_X);
            c2y_q   <= '0;
            c3x_q   <= 10'(LANE2_X);
            c3y_q   <= 10'd240;
            crash_q <= 1'b0;
            score_q <= '0;
            speed_q <= 10'(SPEED0);
            wrap_q  <= '0;
            lfsr_q  <= 8'hA5;
        end else begin
            state_q <= state_d;
            ux_q    <= ux_d;
            c2x_q   <= c2x_d;
            c2y_q   <= c2y_d;
            c3x_q   <= c3x_d;
            c3y_q   <= c3y_d;
            crash_q <= crash_d;
            score_q <= score_d;
            speed_q <= speed_d;
            wrap_q  <= wrap_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_CRASH: if (start) state_d = S_RUN;
            S_RUN:           if (collide) state_d = S_CRASH;
            default:         state_d = S_IDLE;
        endcase
    end

    // Datapath updates. A collision takes priority over a coincident
    // frame_tick, so the scene freezes exactly where the hit was seen.
    always_comb begin
        ux_d    = ux_q;
        c2x_d   = c2x_q;
        c2y_d   = c2y_q;
        c3x_d   = c3x_q;
        c3y_d   = c3y_q;
        crash_d = crash_q;
        score_d = score_q;
        speed_d = speed_q;
        wrap_d  = wrap_q;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (state_q)
            S_IDLE, S_CRASH: begin
                if (start) begin
                    ux_d    = 10'(LANE1_X);
                    c2x_d   = 10'(LANE0_X);
                    c2y_d   = '0;
                    c3x_d   = 10'(LANE2_X);
                    c3y_d   = 10'd240;
                    crash_d = 1'b0;
                    score_d = '0;
                    speed_d = 10'(SPEED0);
                    wrap_d  = '0;
                end
            end
            S_RUN: begin
                if (collide) begin
                    crash_d = 1'b1;
                end else if (frame_tick) begin
                    ux_d    = ux_move;
                    c2y_d   = wrap2 ? '0 : y2_sum[9:0];
                    c2x_d   = wrap2 ? lane_x(lfsr_q[1:0]) : c2x_q;
                    c3y_d   = wrap3 ? '0 : y3_sum[9:0];
                    c3x_d   = wrap3 ? lane_x(lfsr_q[3:2]) : c3x_q;
                    score_d = score_sum[16] ? '1 : score_sum[15:0];
                    wrap_d  = wrap_sum[2:0];
                    // Each carry out of the 3-bit wrap counter bumps the speed.
                    if (wrap_sum[3] && (speed_q < 10'(SPEED_MAX)))
                        speed_d = speed_q + 10'd1;
                end
            end
            default: crash_d = 1'b0;
        endcase
    end

    assign car_user_x = ux_q;
    assign car2_x     = c2x_q;
    assign car2_y     = c2y_q;
    assign car3_x     = c3x_q;
    assign car3_y     = c3y_q;
    assign crash      = crash_q;
    assign score      = score_q;
    assign state      = state_q;
    assign show_cars  = (state_q == S_RUN) || (state_q == S_CRASH);

endmodule
